// File: rtl/riscy_pkg.sv
// Shared decode constants and the ALU control encoding for the ID stage.
package riscy_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b010,
        ALU_OR  = 3'b011,
        ALU_AND = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/id_stage_regfile.sv
// Architectural register file: two async read ports, one sync write port, x0 hardwired to zero.
module id_stage_regfile #(
    parameter int XLEN       = 32,
    parameter bit RESET_REGS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (RESET_REGS && rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// RV32I decode/operand stage: decodes to ALU ctrl, reads operands with writeback bypass,
// tracks pending destinations in a scoreboard and registers the result into ID/EX.
module id_stage
    import riscy_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter bit RESET_REGS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_ctrl,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [4:0]      out_rd_addr,
    output logic            out_we,
    output logic            out_illegal,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;

    assign opcode   = in_instr[6:0];
    assign rd_addr  = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign funct7   = in_instr[31:25];

    alu_ctrl_e dec_ctrl;
    logic      dec_legal;
    logic      is_rtype;

    always_comb begin
        dec_ctrl  = ALU_ADD;
        dec_legal = 1'b0;
        is_rtype  = 1'b0;
        case (opcode)
            OPC_OP: begin
                is_rtype = 1'b1;
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE) begin
                            dec_ctrl  = ALU_ADD;
                            dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_ctrl  = ALU_SUB;
                            dec_legal = 1'b1;
                        end
                    end
                    F3_AND: begin
                        dec_ctrl  = ALU_AND;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    F3_OR: begin
                        dec_ctrl  = ALU_OR;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    F3_SLT: begin
                        dec_ctrl  = ALU_SLT;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    F3_ADD:  begin dec_ctrl = ALU_ADD; dec_legal = 1'b1; end
                    F3_AND:  begin dec_ctrl = ALU_AND; dec_legal = 1'b1; end
                    F3_OR:   begin dec_ctrl = ALU_OR;  dec_legal = 1'b1; end
                    F3_SLT:  begin dec_ctrl = ALU_SLT; dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Illegal encodings are emitted as a plain ADD with no register side effects.
        if (!dec_legal) begin
            dec_ctrl = ALU_ADD;
        end
    end

    logic [XLEN-1:0] rf_rdata_a, rf_rdata_b;

    id_stage_regfile #(
        .XLEN       (XLEN),
        .RESET_REGS (RESET_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (rs1_addr),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (rs2_addr),
        .rdata_b_o (rf_rdata_b),
        .we_i      (wb_we),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    logic            wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic            use_rs1, use_rs2;
    logic [XLEN-1:0] byp_a, byp_b, imm_i, op_a, op_b;

    assign wb_hit_rs1 = wb_we && (wb_addr == rs1_addr);
    assign wb_hit_rs2 = wb_we && (wb_addr == rs2_addr);
    assign wb_hit_rd  = wb_we && (wb_addr == rd_addr);

    assign use_rs1 = dec_legal && (rs1_addr != 5'd0);
    assign use_rs2 = dec_legal && is_rtype && (rs2_addr != 5'd0);

    assign byp_a = (wb_hit_rs1 && (rs1_addr != 5'd0)) ? wb_data : rf_rdata_a;
    assign byp_b = (wb_hit_rs2 && (rs2_addr != 5'd0)) ? wb_data : rf_rdata_b;
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    assign op_a = dec_legal ? byp_a : '0;
    assign op_b = !dec_legal ? '0 : (is_rtype ? byp_b : imm_i);

    logic [31:0] sb_q, sb_d;
    logic        stall, accept;

    // A writeback in this cycle resolves the dependency, so it does not stall.
    assign stall = in_valid && (
                       (use_rs1 && sb_q[rs1_addr] && !wb_hit_rs1) ||
                       (use_rs2 && sb_q[rs2_addr] && !wb_hit_rs2) ||
                       (dec_legal && sb_q[rd_addr] && !wb_hit_rd));

    logic            out_valid_q, out_valid_d;
    alu_ctrl_e       ctrl_q, ctrl_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d, ill_q, ill_d;

    assign in_ready = !stall && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sb_d = sb_q;
        if (wb_we) begin
            sb_d[wb_addr] = 1'b0;
        end
        if (accept && dec_legal && (rd_addr != 5'd0)) begin
            sb_d[rd_addr] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        we_d        = we_q;
        ill_d       = ill_q;
        if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            rs1_d       = op_a;
            rs2_d       = op_b;
            rd_d        = rd_addr;
            we_d        = dec_legal;
            ill_d       = !dec_legal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q        <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= ALU_ADD;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ctrl    = ctrl_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd_addr = rd_q;
    assign out_we      = we_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed vectors checked with immediate assertions.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr;
    logic        out_valid, out_ready;
    logic [2:0]  out_ctrl;
    logic [31:0] out_rs1, out_rs2;
    logic [4:0]  out_rd_addr;
    logic        out_we, out_illegal;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd_addr (out_rd_addr),
        .out_we      (out_we),
        .out_illegal (out_illegal),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic we,
                           input logic ill);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".ctrl"}, out_ctrl, ctrl);
        chk({tag, ".rs1"}, out_rs1, a);
        chk({tag, ".rs2"}, out_rs2, b);
        chk({tag, ".rd"}, out_rd_addr, rd);
        chk({tag, ".we"}, out_we, we);
        chk({tag, ".ill"}, out_illegal, ill);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst.valid", out_valid, 0);
        chk("rst.ctrl", out_ctrl, 0);
        chk("rst.rs1", out_rs1, 0);
        chk("rst.rs2", out_rs2, 0);
        chk("rst.rd", out_rd_addr, 0);
        chk("rst.we", out_we, 0);
        chk("rst.ill", out_illegal, 0);
        chk("rst.in_ready", in_ready, 1);

        // 1: load x1=5, x2=7, then add x3,x1,x2
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        tick();
        wb_addr = 5'd2; wb_data = 32'd7;
        tick();
        wb_we = 1'b0;
        in_valid = 1'b1; in_instr = r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        #1 chk("t1.in_ready", in_ready, 1);
        tick();
        chk_out("t1.add", 3'b000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("t1.drain", out_valid, 0);

        // 2: addi x4,x0,-1 ; addi x0,x0,5 ; write attempt to x0 ; add x12,x0,x0
        in_valid = 1'b1; in_instr = i_ins(12'hFFF, 5'd0, 3'b000, 5'd4);
        tick();
        chk_out("t2.addi", 3'b000, 32'd0, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0);
        in_instr = i_ins(12'd5, 5'd0, 3'b000, 5'd0);
        tick();
        chk_out("t2.addi_x0", 3'b000, 32'd0, 32'd5, 5'd0, 1'b1, 1'b0);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h63;
        in_instr = r_ins(7'h00, 5'd0, 5'd0, 3'b000, 5'd7);
        tick();
        wb_we = 1'b0;
        chk_out("t2.x0_byp", 3'b000, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0);
        in_instr = r_ins(7'h00, 5'd0, 5'd0, 3'b000, 5'd12);
        tick();
        chk_out("t2.x0_read", 3'b000, 32'd0, 32'd0, 5'd12, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();

        // 3: add x5,x1,x2 then sub x6,x5,x1 stalls until x5 is written back
        in_valid = 1'b1; in_instr = r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd5);
        tick();
        chk_out("t3.add", 3'b000, 32'd5, 32'd7, 5'd5, 1'b1, 1'b0);
        in_instr = r_ins(7'h20, 5'd1, 5'd5, 3'b000, 5'd6);
        #1 chk("t3.stall0", in_ready, 0);
        tick();
        chk("t3.stall1", in_ready, 0);
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'd12;
        #1 chk("t3.wb_ready", in_ready, 1);
        tick();
        wb_we = 1'b0;
        chk_out("t3.sub", 3'b010, 32'd12, 32'd5, 5'd6, 1'b1, 1'b0);

        // 4: backpressure for 3 cycles with or x8,x1,x2 waiting
        out_ready = 1'b0;
        in_instr = r_ins(7'h00, 5'd2, 5'd1, 3'b110, 5'd8);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4.in_ready", in_ready, 0);
            tick();
            chk_out("t4.hold", 3'b010, 32'd12, 32'd5, 5'd6, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        #1 chk("t4.release", in_ready, 1);
        tick();
        chk_out("t4.or", 3'b011, 32'd5, 32'd7, 5'd8, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("t4.no_dup", out_valid, 0);

        // 5: jal is illegal and leaves the scoreboard alone; back-to-back issue follows
        in_valid = 1'b1; in_instr = 32'h0000_006F;
        #1 chk("t5.jal_ready", in_ready, 1);
        tick();
        chk_out("t5.jal", 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        in_instr = i_ins(12'd6, 5'd1, 3'b010, 5'd9);
        #1 chk("t5.next_ready", in_ready, 1);
        tick();
        chk_out("t5.slti", 3'b101, 32'd5, 32'd6, 5'd9, 1'b1, 1'b0);
        in_instr = i_ins(12'd3, 5'd2, 3'b111, 5'd10);
        tick();
        chk_out("t5.andi", 3'b100, 32'd7, 32'd3, 5'd10, 1'b1, 1'b0);

        // 6: reset while holding output and with x9 pending clears both
        in_instr = r_ins(7'h00, 5'd0, 5'd9, 3'b000, 5'd11);
        #1 chk("t6.raw_stall", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.valid_clr", out_valid, 0);
        #1 chk("t6.no_stall", in_ready, 1);
        in_instr = r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd13);
        tick();
        chk_out("t6.regs_clr", 3'b000, 32'd0, 32'd0, 5'd13, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
